// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words for the IM write port,
// holding the core (cpu_hold -> rst_pc) while a program is loaded.
//
// Parameters:
//   ADDR_W    IM word-address width (depth = 2**ADDR_W words, ADDR_W <= 16)
//   BASE_ADDR first IM word address written
// Ports:
//   clk, rst_loader (async, active high)
//   start                    one-cycle load request (IDLE/DONE/ERR only)
//   byte_valid/byte_data     byte source, transfer on byte_valid && byte_ready
//   byte_ready               loader accepts a byte
//   im_we/im_waddr/im_wdata  IM write port, one strobe per word
//   cpu_hold                 high while loading (and in ERR)
//   busy, done, ovf, err     status
//   words_written            words committed to the IM this load
// Frame: count N (2 bytes, MSB first), 4N data bytes, then a checksum byte
// when IMEM_LOADER_CHECKSUM_EN is defined (XOR of all header and data bytes).
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_loader,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    FLUSH,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH =
    17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t EMPTY_NX = CHK;
  localparam state_t TAIL_NX  = CHK;
`else
  localparam state_t EMPTY_NX = DONE;
  localparam state_t TAIL_NX  = FLUSH;
`endif

  state_t      state;
  state_t      state_nx;
  logic [15:0] hdr;
  logic [15:0] hdr_n;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
  logic        fire;
  logic        go;
  logic        word_done;
  logic        last_byte;
  logic        in_range;

  assign fire = byte_valid && byte_ready;

  assign go = start &&
    (state == IDLE || state == DONE ||
     state == ERR);

  // Full count as it will be after the
  // low header byte is captured.
  assign hdr_n = {hdr[15:8], byte_data};

  assign word_done = (state == DATA) &&
    fire && (bcnt == 2'd3);

  assign last_byte = word_done &&
    (idx == hdr - 16'd1);

  // Words beyond the IM depth are consumed
  // but never written.
  assign in_range = {1'b0, idx} < DEPTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst_loader) begin
    if (rst_loader) begin
      csum <= 8'd0;
    end else if (go) begin
      csum <= 8'd0;
    end else if (fire && state != CHK) begin
      csum <= csum ^ byte_data;
    end
  end

  assign err = (state == ERR);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_loader) begin
    if (rst_loader) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nx = HDR_HI;
      end
      HDR_HI: begin
        if (fire) state_nx = HDR_LO;
      end
      HDR_LO: begin
        if (fire) begin
          state_nx = (hdr_n == 16'd0) ?
            EMPTY_NX : DATA;
        end
      end
      DATA: begin
        if (last_byte) state_nx = TAIL_NX;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) begin
          state_nx = (byte_data == csum) ?
            FLUSH : ERR;
        end
      end
`endif
      FLUSH: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA, CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      FLUSH: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      ERR: begin
        cpu_hold = 1'b1;
      end
      default: begin
        byte_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_loader) begin
    if (rst_loader) begin
      hdr           <= 16'd0;
      idx           <= 16'd0;
      bcnt          <= 2'd0;
      shreg         <= 24'd0;
      ovf           <= 1'b0;
      words_written <= '0;
      im_we         <= 1'b0;
      im_waddr      <= '0;
      im_wdata      <= 32'd0;
    end else begin
      im_we <= 1'b0;
      if (go) begin
        hdr           <= 16'd0;
        idx           <= 16'd0;
        bcnt          <= 2'd0;
        shreg         <= 24'd0;
        ovf           <= 1'b0;
        words_written <= '0;
      end else if (fire) begin
        case (state)
          HDR_HI: begin
            hdr[15:8] <= byte_data;
          end
          HDR_LO: begin
            hdr[7:0] <= byte_data;
            ovf <= {1'b0, hdr_n} > DEPTH;
          end
          DATA: begin
            shreg <= {shreg[15:0], byte_data};
            bcnt  <= bcnt + 2'd1;
            if (word_done) begin
              idx <= idx + 16'd1;
              if (in_range) begin
                im_we    <= 1'b1;
                im_waddr <= BASE +
                  idx[ADDR_W-1:0];
                im_wdata <= {shreg, byte_data};
                words_written <= words_written +
                  (ADDR_W+1)'(1);
              end
            end
          end
          default: begin
            bcnt <= bcnt;
          end
        endcase
      end
    end
  end

endmodule
